// File: rtl/sticky_status_pkg.sv
// Shared types and default sizing for the sticky status / interrupt block.
//   irq_state_t : interrupt FSM state encoding (2 bits)
//   DEF_WIDTH   : default number of status/event bits
//   DEF_HOLDOFF_W : default width of the hold-off counter
package sticky_status_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_HOLDOFF_W = 8;

endpackage

// File: rtl/edge_detect_vec.sv
// Per-bit event detector.
//   Clk, Rst  : clock, synchronous active-high reset
//   Event_in  : raw hardware event sources
//   Edge_mode : per bit, 1 = rising edge, 0 = level
//   Det       : one-cycle detect (edge) or follow-the-input (level)
module edge_detect_vec #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Event_in,
    input  logic [WIDTH-1:0] Edge_mode,
    output logic [WIDTH-1:0] Det
);

    // prev_event clears on reset, so an input already high on the first
    // cycle after reset is seen as a rising edge.
    logic [WIDTH-1:0] prev_event;

    always_ff @(posedge Clk) begin
        if (Rst) prev_event <= '0;
        else     prev_event <= Event_in;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_det
        assign Det[i] = Edge_mode[i] ? (Event_in[i] & ~prev_event[i]) : Event_in[i];
    end

endmodule

// File: rtl/sticky_status_irq.sv
// Sticky hardware status capture with W1C clear, mask and a level interrupt
// with programmable hold-off before re-arming.
//   Clk, Rst     : clock, synchronous active-high reset
//   Event_in     : hardware event sources
//   Edge_mode    : per bit 1 = rising-edge detect, 0 = level
//   Clr_en/Clr_data     : write-1-to-clear strobe and data
//   Mask_wr_en/Mask_data: mask register write (1 = interrupt enabled)
//   Holdoff_in   : hold-off length, sampled when leaving ASSERT
//   Status_out   : sticky status bits
//   Overflow_out : event seen while the status bit was already set
//   Mask_out     : mask register
//   Irq          : interrupt request, high while the FSM is in ASSERT
module sticky_status_irq
    import sticky_status_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HOLDOFF_W = DEF_HOLDOFF_W
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [WIDTH-1:0]     Event_in,
    input  logic [WIDTH-1:0]     Edge_mode,
    input  logic                 Clr_en,
    input  logic [WIDTH-1:0]     Clr_data,
    input  logic                 Mask_wr_en,
    input  logic [WIDTH-1:0]     Mask_data,
    input  logic [HOLDOFF_W-1:0] Holdoff_in,
    output logic [WIDTH-1:0]     Status_out,
    output logic [WIDTH-1:0]     Overflow_out,
    output logic [WIDTH-1:0]     Mask_out,
    output logic                 Irq
);

    logic [WIDTH-1:0]     det;
    logic [WIDTH-1:0]     clr;
    logic                 pending;
    irq_state_t           state_q, state_d;
    logic [HOLDOFF_W-1:0] cnt_q, cnt_d;

    edge_detect_vec #(.WIDTH(WIDTH)) u_det (
        .Clk       (Clk),
        .Rst       (Rst),
        .Event_in  (Event_in),
        .Edge_mode (Edge_mode),
        .Det       (det)
    );

    assign clr = Clr_en ? Clr_data : '0;

    // Set wins over a same-cycle clear; an event racing its own clear is
    // treated as a fresh capture, not an overflow.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Status_out   <= '0;
            Overflow_out <= '0;
            Mask_out     <= '0;
        end else begin
            Status_out   <= (Status_out & ~clr) | det;
            Overflow_out <= (Overflow_out & ~clr) | (det & Status_out & ~clr);
            if (Mask_wr_en) Mask_out <= Mask_data;
        end
    end

    // Registered status and mask only, so Irq trails status by one cycle.
    assign pending = |(Status_out & Mask_out);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pending) state_d = ASSERT;
            end
            ASSERT: begin
                if (!pending) begin
                    if (Holdoff_in != '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = Holdoff_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                // Counter parks at 1 on exit; it never wraps through zero.
                if (cnt_q <= HOLDOFF_W'(1)) state_d = IDLE;
                else                        cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Irq = (state_q == ASSERT);

endmodule

// File: tb/tb_sticky_status_irq.sv
module tb_sticky_status_irq;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] Event_in, Edge_mode, Clr_data, Mask_data, Holdoff_in;
    logic       Clr_en, Mask_wr_en;
    logic [7:0] Status_out, Overflow_out, Mask_out;
    logic       Irq;

    int checks = 0;
    int errors = 0;

    sticky_status_irq #(.WIDTH(8), .HOLDOFF_W(8)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Event_in     (Event_in),
        .Edge_mode    (Edge_mode),
        .Clr_en       (Clr_en),
        .Clr_data     (Clr_data),
        .Mask_wr_en   (Mask_wr_en),
        .Mask_data    (Mask_data),
        .Holdoff_in   (Holdoff_in),
        .Status_out   (Status_out),
        .Overflow_out (Overflow_out),
        .Mask_out     (Mask_out),
        .Irq          (Irq)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; Event_in = 8'h01; Edge_mode = 8'h01;
        Clr_en = 1'b0; Clr_data = 8'h00; Mask_wr_en = 1'b0; Mask_data = 8'h00;
        Holdoff_in = 8'h00;
        step(); step();
        chk("rst_status", Status_out, 8'h00);
        chk("rst_ovf",    Overflow_out, 8'h00);
        chk("rst_mask",   Mask_out, 8'h00);
        chk("rst_irq",    Irq, 1'b0);

        // 1: input high at reset release counts as an edge
        Rst = 1'b0; Mask_wr_en = 1'b1; Mask_data = 8'h01;
        step(); Mask_wr_en = 1'b0;
        chk("t1_status", Status_out, 8'h01);
        chk("t1_mask",   Mask_out, 8'h01);
        chk("t1_irq_n1", Irq, 1'b0);
        step();
        chk("t1_irq_n2", Irq, 1'b1);
        step();
        chk("t1_ovf_hold", Overflow_out, 8'h00);

        // 2: level bit 3 held for 3 cycles
        Event_in = 8'h09;
        step();
        chk("t2_status_c1", Status_out, 8'h09);
        chk("t2_ovf_c1",    Overflow_out, 8'h00);
        step();
        chk("t2_ovf_c2",    Overflow_out, 8'h08);
        step();
        Event_in = 8'h01;
        chk("t2_status_c3", Status_out, 8'h09);
        chk("t2_ovf_c3",    Overflow_out, 8'h08);
        Clr_en = 1'b1; Clr_data = 8'hFF;
        step(); Clr_en = 1'b0;
        chk("t2_clr_status", Status_out, 8'h00);
        chk("t2_clr_ovf",    Overflow_out, 8'h00);

        // 3: W1C racing a new edge on bit 2
        Edge_mode = 8'h05; Event_in = 8'h05;
        step();
        chk("t3_set", Status_out, 8'h04);
        Event_in = 8'h01;
        step();
        Event_in = 8'h05; Clr_en = 1'b1; Clr_data = 8'h04;
        step();
        chk("t3_race_status", Status_out, 8'h04);
        chk("t3_race_ovf",    Overflow_out, 8'h00);
        Event_in = 8'h01;
        step(); Clr_en = 1'b0;
        chk("t3_w1c_status", Status_out, 8'h00);
        chk("t3_w1c_ovf",    Overflow_out, 8'h00);

        // 4: masked event, then unmask
        Mask_wr_en = 1'b1; Mask_data = 8'h00;
        step(); Mask_wr_en = 1'b0;
        Event_in = 8'h21;
        step(); Event_in = 8'h01;
        chk("t4_status", Status_out, 8'h20);
        step();
        chk("t4_irq_masked_a", Irq, 1'b0);
        step();
        chk("t4_irq_masked_b", Irq, 1'b0);
        Mask_wr_en = 1'b1; Mask_data = 8'h20;
        step(); Mask_wr_en = 1'b0;
        chk("t4_mask",    Mask_out, 8'h20);
        chk("t4_irq_m1",  Irq, 1'b0);
        step();
        chk("t4_irq_m2",  Irq, 1'b1);

        // 5: hold-off of 4 with a new event right after the clear
        Holdoff_in = 8'd4; Clr_en = 1'b1; Clr_data = 8'hFF;
        step(); Clr_en = 1'b0;
        chk("t5_clr_status", Status_out, 8'h00);
        chk("t5_irq_e1",     Irq, 1'b1);
        Event_in = 8'h21;
        step(); Event_in = 8'h01;
        chk("t5_repend", Status_out, 8'h20);
        chk("t5_irq_low0", Irq, 1'b0);
        Holdoff_in = 8'd9;  // must not stretch the running hold-off
        for (int i = 1; i < 5; i++) begin
            step();
            chk($sformatf("t5_irq_low%0d", i), Irq, 1'b0);
        end
        step();
        chk("t5_irq_rearm", Irq, 1'b1);

        // 6: reset during hold-off
        Holdoff_in = 8'd4; Clr_en = 1'b1; Clr_data = 8'hFF;
        step(); Clr_en = 1'b0;
        Event_in = 8'h21;
        step(); Event_in = 8'h01;
        chk("t6_in_holdoff_irq", Irq, 1'b0);
        chk("t6_in_holdoff_st",  Status_out, 8'h20);
        Rst = 1'b1;
        step(); Rst = 1'b0;
        chk("t6_rst_status", Status_out, 8'h00);
        chk("t6_rst_ovf",    Overflow_out, 8'h00);
        chk("t6_rst_mask",   Mask_out, 8'h00);
        chk("t6_rst_irq",    Irq, 1'b0);
        Mask_wr_en = 1'b1; Mask_data = 8'h01;
        step(); Mask_wr_en = 1'b0;
        chk("t6_post_status", Status_out, 8'h01);
        step();
        chk("t6_post_irq", Irq, 1'b1);

        // Zero hold-off: drop straight to IDLE and re-assert on next pending
        Holdoff_in = 8'd0; Clr_en = 1'b1; Clr_data = 8'hFF; Event_in = 8'h00;
        step(); Clr_en = 1'b0;
        chk("t6_h0_status", Status_out, 8'h00);
        chk("t6_h0_irq_e1", Irq, 1'b1);
        step();
        chk("t6_h0_irq_e2", Irq, 1'b0);
        Event_in = 8'h01;
        step();
        chk("t6_h0_status2", Status_out, 8'h01);
        chk("t6_h0_irq_e3",  Irq, 1'b0);
        step();
        chk("t6_h0_irq_e4",  Irq, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sticky_status_irq.md
Name: sticky_status_irq

Overview:
Hardware-to-software status capture block: the complement of the self-clearing control pulse path.
- Per-bit hardware event pulses or levels set sticky status bits.
- Software clears the bits with write-1-to-clear.
- A maskable, registered interrupt with a programmable hold-off re-arm delay is produced.
- Sits between peripheral/miner cores and the CSR bus slave.

Parameters:
WIDTH, 8, number of status/event bits
HOLDOFF_W, 8, width of the interrupt hold-off counter

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Event_in  in  WIDTH  hardware event sources
Edge_mode  in  WIDTH  per bit: 1 = rising-edge detect, 0 = level (set every cycle high)
Clr_en  in  1  W1C write strobe
Clr_data  in  WIDTH  W1C data; 1 clears the corresponding status and overflow bit
Mask_wr_en  in  1  mask register write strobe
Mask_data  in  WIDTH  new mask value (1 = interrupt enabled)
Holdoff_in  in  HOLDOFF_W  hold-off length in cycles, sampled on entry to HOLDOFF
Status_out  out  WIDTH  sticky status register
Overflow_out  out  WIDTH  event arrived while status bit already set
Mask_out  out  WIDTH  mask register
Irq  out  1  interrupt request, level

Behaviour:
- One clock domain (Clk); reset is synchronous and active-high (Rst). All state updates on the Clk rising edge.
- Reset values: Status_out=0, Overflow_out=0, Mask_out=0, Irq=0, prev_event=0, FSM=IDLE, hold-off counter=0. Reset mid-operation, including mid-HOLDOFF, returns all of these to reset values on the next edge.
- Detection: det[i] = Edge_mode[i] ? (Event_in[i] & ~prev_event[i]) : Event_in[i].
  - prev_event <= Event_in every cycle.
  - Input high at the first cycle after reset counts as an edge.
- Effective clear: clr = Clr_en ? Clr_data : 0.
- Status: status <= (status & ~clr) | det. Set wins over a simultaneous clear.
- Overflow: ovf[i] <= (ovf[i] & ~clr[i]) | (det[i] & status[i] & ~clr[i]).
  - An event coinciding with a clear of the same bit sets status and does not set overflow.
- Mask: Mask_out <= Mask_data when Mask_wr_en.
- pending = |(Status_out & Mask_out), computed from registered values.
- Irq FSM, Irq = (state == ASSERT):
  - IDLE: pending -> ASSERT.
  - ASSERT: pending==0 -> HOLDOFF if Holdoff_in != 0, loading cnt = Holdoff_in; else -> IDLE.
  - HOLDOFF: cnt decrements each cycle; when cnt==1 -> IDLE. Irq is low for exactly Holdoff_in cycles, then IDLE re-evaluates pending. Pending during HOLDOFF is ignored. Holdoff_in changes during HOLDOFF are ignored.
- Latency:
  - Event at cycle n -> Status_out visible n+1 -> Irq high n+2.
  - Clear at cycle m, no other pending -> Status_out low m+1 -> Irq low m+2.
- Masking all pending bits while in ASSERT behaves as a clear (pending drops, FSM leaves ASSERT).
- No wrap-around: the counter never decrements below 1 in HOLDOFF.

Decomposition:
- Package sticky_status_pkg:
  - irq_state_t enum {IDLE, ASSERT, HOLDOFF}, 2-bit encoding
  - localparam defaults for WIDTH and HOLDOFF_W
- Sub-module edge_detect_vec (WIDTH param): prev_event register and det generation with Edge_mode.
- FSM, status, overflow and mask registers stay in the top module.

Test Plan:
1. Reset release with Event_in=8'h01, Edge_mode=8'h01, Mask=8'h01 -> Status_out=8'h01 after 1 cycle, Irq=1 after 2 cycles; holding Event_in high produces no overflow.
2. Level mode bit 3: Event_in[3] high for 3 cycles, Edge_mode=0 -> Status_out[3]=1 from cycle 2; Overflow_out[3]=1 from cycle 3.
3. W1C on the same cycle as a new edge on bit 2 -> Status_out[2] stays 1, Overflow_out[2] stays 0. W1C alone on bit 2 -> both 0 next cycle.
4. Mask=0, event on bit 5 -> Status_out[5]=1, Irq stays 0. Then Mask_data=8'h20 -> Irq=1 two cycles after the mask write.
5. Holdoff_in=4, Irq high, clear all with new event pending on cycle after the clear -> Irq low exactly 4 cycles, then high again 1 cycle after returning to IDLE.
6. Assert Rst during HOLDOFF with status set -> next cycle all outputs 0, FSM=IDLE; Holdoff_in=0 path: clear -> Irq drops with no hold-off and re-asserts on next pending.
